// File: rtl/game_status_tracker_if.sv
// Event and status bundle between the sprite/collision logic, the game-flow FSM
// and game_status_tracker. The master drives events; the tracker (slave) drives status.
interface game_status_tracker_if;
    logic        start;
    logic        is_playing;
    logic        frame_tick;
    logic        alien_hit;
    logic [1:0]  alien_row;
    logic        player_hit;
    logic        invaders_landed;
    logic        wave_cleared;
    logic        finished;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic [1:0]  lives;
    logic [3:0]  wave;
    logic        invulnerable;

    modport master (
        output start, is_playing, frame_tick, alien_hit, alien_row,
               player_hit, invaders_landed, wave_cleared,
        input  finished, score, hi_score, lives, wave, invulnerable
    );

    modport slave (
        input  start, is_playing, frame_tick, alien_hit, alien_row,
               player_hit, invaders_landed, wave_cleared,
        output finished, score, hi_score, lives, wave, invulnerable
    );
endinterface

// File: rtl/game_status_tracker.sv
// Score (4-digit BCD), lives, wave and game-over tracking for one game.
// Define GAME_HISCORE_EN to build the high-score register; otherwise hi_score reads 0.
module game_status_tracker #(
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 90
) (
    input  logic                   clk,
    input  logic                   reset,
    game_status_tracker_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, PLAYING, RESPAWN, OVER} state_t;

    state_t      state, state_next;
    logic [15:0] score, score_next;
    logic [1:0]  lives, lives_next;
    logic [3:0]  wave, wave_next;
    logic        finished, finished_next;
    logic [7:0]  respawn_cnt, respawn_cnt_next;
    logic        invulnerable;
    logic [1:0]  hit_tens;

    // Adds 10, 20 or 30 to a BCD word; the ones digit never changes.
    function automatic logic [15:0] bcd_add_tens(input logic [15:0] value, input logic [1:0] tens);
        logic [15:0] sum;
        logic [3:0]  digit;
        logic        carry;
        sum   = value;
        digit = value[7:4] + {2'b00, tens};
        carry = 1'b0;
        if (digit > 4'd9) begin
            digit = digit - 4'd10;
            carry = 1'b1;
        end
        sum[7:4] = digit;
        digit = value[11:8] + {3'b000, carry};
        carry = 1'b0;
        if (digit > 4'd9) begin
            digit = digit - 4'd10;
            carry = 1'b1;
        end
        sum[11:8] = digit;
        digit = value[15:12] + {3'b000, carry};
        carry = 1'b0;
        if (digit > 4'd9) begin
            digit = digit - 4'd10;
            carry = 1'b1;
        end
        sum[15:12] = digit;
        if (carry) sum = 16'h9999;
        return sum;
    endfunction

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_next       = state;
        score_next       = score;
        lives_next       = lives;
        wave_next        = wave;
        finished_next    = finished;
        respawn_cnt_next = respawn_cnt;
        case (bus.alien_row)
            2'd0:    hit_tens = 2'd3;
            2'd1:    hit_tens = 2'd2;
            default: hit_tens = 2'd1;
        endcase

        if (bus.start) begin
            state_next       = PLAYING;
            score_next       = 16'h0000;
            lives_next       = 2'(START_LIVES);
            wave_next        = 4'd1;
            finished_next    = 1'b0;
            respawn_cnt_next = 8'd0;
        end else if ((state == PLAYING || state == RESPAWN) && bus.is_playing) begin
            // Score and wave still count in the cycle that ends the game.
            if (bus.alien_hit)
                score_next = bcd_add_tens(score, hit_tens);
            if (bus.wave_cleared && wave != 4'd15)
                wave_next = wave + 4'd1;

            if (bus.invaders_landed) begin
                state_next    = OVER;
                lives_next    = 2'd0;
                finished_next = 1'b1;
            end else if (bus.player_hit && state == PLAYING) begin
                if (lives == 2'd1) begin
                    state_next    = OVER;
                    lives_next    = 2'd0;
                    finished_next = 1'b1;
                end else begin
                    state_next       = RESPAWN;
                    lives_next       = lives - 2'd1;
                    respawn_cnt_next = 8'(RESPAWN_FRAMES);
                end
            end else if (bus.frame_tick && state == RESPAWN) begin
                respawn_cnt_next = respawn_cnt - 8'd1;
                if (respawn_cnt == 8'd1)
                    state_next = PLAYING;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            score        <= 16'h0000;
            lives        <= 2'd0;
            wave         <= 4'd0;
            finished     <= 1'b0;
            respawn_cnt  <= 8'd0;
            invulnerable <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state        <= state_next;
            score        <= score_next;
            lives        <= lives_next;
            wave         <= wave_next;
            finished     <= finished_next;
            respawn_cnt  <= respawn_cnt_next;
            invulnerable <= (state_next == RESPAWN);
        end
    end

`ifdef GAME_HISCORE_EN
    logic [15:0] hi_score;

    // Score is frozen in OVER, so comparing on every OVER edge equals comparing on the first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hi_score <= 16'h0000;
        else if (state == OVER && score > hi_score)
            hi_score <= score;
    end

    assign bus.hi_score = hi_score;
`else
    assign bus.hi_score = 16'h0000;
`endif

    assign bus.finished     = finished;
    assign bus.score        = score;
    assign bus.lives        = lives;
    assign bus.wave         = wave;
    assign bus.invulnerable = invulnerable;

endmodule

// File: tb/tb_game_status_tracker.sv
// Self-checking bench for game_status_tracker against an integer-arithmetic game model.
// Honours GAME_HISCORE_EN when predicting hi_score.
module tb_game_status_tracker;

    localparam int RESPAWN = 90;

    logic clk = 1'b0;
    logic reset;
    bit   playing;

    always #5 clk = ~clk;

    game_status_tracker_if bus();

    game_status_tracker #(.START_LIVES(3), .RESPAWN_FRAMES(RESPAWN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: plain integers; "in game" covers play and respawn, m_resp > 0 means invulnerable.
    bit m_in_game, m_over, m_finished;
    int m_score, m_best, m_lives, m_wave, m_resp;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [39:0] model_vec();
        logic [15:0] hi;
`ifdef GAME_HISCORE_EN
        hi = to_bcd(m_best);
`else
        hi = 16'h0000;
`endif
        return {m_finished, to_bcd(m_score), hi, 2'(m_lives), 4'(m_wave), (m_in_game && m_resp > 0)};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {bus.finished, bus.score, bus.hi_score, bus.lives, bus.wave, bus.invulnerable};
    endfunction

    task automatic model_reset();
        m_in_game = 0; m_over = 0; m_finished = 0;
        m_score = 0; m_best = 0; m_lives = 0; m_wave = 0; m_resp = 0;
    endtask

    task automatic model_step(input bit st, ft, ah, input logic [1:0] ar, input bit ph, il, wc);
        bit old_over;
        int old_score, pts;
        old_over  = m_over;
        old_score = m_score;
        if (st) begin
            m_score = 0; m_lives = 3; m_wave = 1; m_finished = 0;
            m_resp = 0; m_in_game = 1; m_over = 0;
        end else if (m_in_game && playing) begin
            pts = (ar == 2'd0) ? 30 : (ar == 2'd1) ? 20 : 10;
            if (ah) m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
            if (wc && m_wave < 15) m_wave++;
            if (il || (ph && m_resp == 0 && m_lives == 1)) begin
                m_lives = 0; m_finished = 1; m_in_game = 0; m_over = 1; m_resp = 0;
            end else if (ph && m_resp == 0) begin
                m_lives--; m_resp = RESPAWN;
            end else if (ft && m_resp > 0) begin
                m_resp--;
            end
        end
        // Best score is taken one edge after the game ends.
        if (old_over && old_score > m_best) m_best = old_score;
    endtask

    // One clock: drive events, model the edge, settle to the falling edge, clear pulses.
    task automatic cycle(input bit st, ft, ah, input logic [1:0] ar, input bit ph, il, wc);
        bus.is_playing = playing;
        bus.start = st; bus.frame_tick = ft; bus.alien_hit = ah; bus.alien_row = ar;
        bus.player_hit = ph; bus.invaders_landed = il; bus.wave_cleared = wc;
        @(posedge clk);
        model_step(st, ft, ah, ar, ph, il, wc);
        @(negedge clk);
        bus.start = 0; bus.frame_tick = 0; bus.alien_hit = 0; bus.alien_row = 2'd0;
        bus.player_hit = 0; bus.invaders_landed = 0; bus.wave_cleared = 0;
    endtask

    task automatic test_reset();
        playing = 1;
        reset = 1'b0;
        cycle(0, 0, 0, 2'd0, 0, 0, 0);
        model_reset();
        n_checks++;
        if (dut_vec() !== 40'h0) begin n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 40'h0); end
        reset = 1'b1;
        cycle(0, 1, 1, 2'd0, 1, 1, 1);
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL idle_ignores: got %h expected %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_start();
        playing = 1;
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        n_checks++;
        if ({bus.lives, bus.wave, bus.score, bus.finished, bus.invulnerable} !== {2'd3, 4'd1, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL start_values: got lives=%0d wave=%0d score=%h fin=%b inv=%b expected 3 1 0000 0 0",
                     bus.lives, bus.wave, bus.score, bus.finished, bus.invulnerable);
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL start_model: got %h expected %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_scoring();
        logic [1:0]  rows [3] = '{2'd0, 2'd1, 2'd3};
        logic [15:0] want [3] = '{16'h0030, 16'h0050, 16'h0060};
        playing = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, rows[i], 0, 0, 0);
            n_checks++;
            if (bus.score !== want[i]) begin n_fail++; $display("FAIL score_row%0d: got %h expected %h", rows[i], bus.score, want[i]); end
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL score_model: got %h expected %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_respawn();
        playing = 1;
        cycle(0, 0, 0, 2'd0, 1, 0, 0);
        n_checks++;
        if ({bus.lives, bus.invulnerable} !== {2'd2, 1'b1}) begin
            n_fail++; $display("FAIL first_hit: got lives=%0d inv=%b expected 2 1", bus.lives, bus.invulnerable);
        end
        cycle(0, 0, 0, 2'd0, 1, 0, 0);
        n_checks++;
        if (bus.lives !== 2'd2) begin n_fail++; $display("FAIL hit_in_respawn: got lives=%0d expected 2", bus.lives); end
        for (int i = 0; i < RESPAWN; i++) begin
            cycle(0, 1, 0, 2'd0, 0, 0, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL respawn_tick%0d: got %h expected %h", i, dut_vec(), model_vec()); end
        end
        n_checks++;
        if (bus.invulnerable !== 1'b0) begin n_fail++; $display("FAIL respawn_end: got inv=%b expected 0", bus.invulnerable); end
    endtask

    task automatic test_game_over();
        logic [15:0] exp_hi, final_score;
        playing = 1;
        cycle(0, 0, 0, 2'd0, 1, 0, 0);
        repeat (RESPAWN) cycle(0, 1, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 1, 0, 0);
        n_checks++;
        if (bus.finished !== 1'b1 || bus.lives !== 2'd0) begin
            n_fail++; $display("FAIL last_life: got fin=%b lives=%0d expected 1 0", bus.finished, bus.lives);
        end
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL over_model: got %h expected %h", dut_vec(), model_vec()); end
        final_score = to_bcd(m_score);
`ifdef GAME_HISCORE_EN
        exp_hi = final_score;
`else
        exp_hi = 16'h0000;
`endif
        cycle(0, 0, 0, 2'd0, 0, 0, 0);
        n_checks++;
        if (bus.hi_score !== exp_hi) begin n_fail++; $display("FAIL hi_update: got %h expected %h", bus.hi_score, exp_hi); end
        cycle(0, 1, 1, 2'd0, 1, 1, 1);
        n_checks++;
        if ({bus.finished, bus.score, bus.wave} !== {1'b1, final_score, 4'd1}) begin
            n_fail++; $display("FAIL over_ignores: got fin=%b score=%h wave=%0d expected 1 %h 1", bus.finished, bus.score, bus.wave, final_score);
        end
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        n_checks++;
        if ({bus.finished, bus.score, bus.hi_score} !== {1'b0, 16'h0000, exp_hi}) begin
            n_fail++; $display("FAIL restart: got fin=%b score=%h hi=%h expected 0 0000 %h", bus.finished, bus.score, bus.hi_score, exp_hi);
        end
    endtask

    task automatic test_same_cycle();
        playing = 1;
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 1, 2'd2, 1, 1, 0);
        n_checks++;
        if ({bus.lives, bus.score, bus.finished} !== {2'd0, 16'h0010, 1'b1}) begin
            n_fail++; $display("FAIL land_priority: got lives=%0d score=%h fin=%b expected 0 0010 1", bus.lives, bus.score, bus.finished);
        end
    endtask

    task automatic test_back_to_back();
        playing = 1;
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 2'($urandom_range(0, 3)), 0, 0, 1);
            n_checks++;
            if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, dut_vec(), model_vec()); end
        end
    endtask

    task automatic test_saturation();
        playing = 1;
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        repeat (999) cycle(0, 0, 1, 2'd3, 0, 0, 0);
        n_checks++;
        if (bus.score !== 16'h9990) begin n_fail++; $display("FAIL preload: got %h expected 9990", bus.score); end
        cycle(0, 0, 1, 2'd0, 0, 0, 0);
        n_checks++;
        if (bus.score !== 16'h9999) begin n_fail++; $display("FAIL score_sat: got %h expected 9999", bus.score); end
        cycle(0, 0, 1, 2'd1, 0, 0, 0);
        n_checks++;
        if (bus.score !== 16'h9999) begin n_fail++; $display("FAIL score_hold: got %h expected 9999", bus.score); end
        repeat (20) cycle(0, 0, 0, 2'd0, 0, 0, 1);
        n_checks++;
        if (bus.wave !== 4'd15) begin n_fail++; $display("FAIL wave_sat: got %0d expected 15", bus.wave); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            playing = ($urandom_range(0, 99) < 85);
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
                  2'($urandom_range(0, 3)), $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 10);
            n_checks++;
            if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), model_vec()); end
        end
    endtask

    task automatic test_reset_mid_respawn();
        playing = 1;
        cycle(1, 0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 1, 2'd0, 1, 0, 0);
        #2 reset = 1'b0;
        #1 model_reset();
        n_checks++;
        if (dut_vec() !== 40'h0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 40'h0); end
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 1, 1, 2'd0, 1, 0, 1);
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL post_reset_idle: got %h expected %h", dut_vec(), model_vec()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_scoring();
        test_respawn();
        test_game_over();
        test_same_cycle();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid_respawn();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_status_tracker.md
# game_status_tracker

Tracks score, lives, wave number and game-over status for one game and produces the `finished` level consumed by the game-flow FSM. Sits directly upstream of that FSM: takes its `start` pulse and `is_playing` level back in, and takes hit/landing/wave events from the sprite and collision logic. Score is kept in 4-digit BCD for direct use by the on-screen digit renderer.

## Interface
- `START_LIVES`, 3: lives loaded on `start`; legal range 1..3.
- `RESPAWN_FRAMES`, 90: frames of invulnerability after a non-fatal player hit; legal range 1..255.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state including high score.
- `start`  in  1  one-cycle pulse from the game-flow FSM; begins a new game.
- `is_playing`  in  1  game-flow FSM level; events are ignored while low.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `alien_hit`  in  1  one-cycle pulse; a player shot destroyed an alien.
- `alien_row`  in  2  row of the destroyed alien, valid with `alien_hit`; 0 = top.
- `player_hit`  in  1  one-cycle pulse; the player ship was hit.
- `invaders_landed`  in  1  one-cycle pulse; an alien reached the player line.
- `wave_cleared`  in  1  one-cycle pulse; all aliens in the current wave are destroyed.
- `finished`  out  1  game over; level, held until the next `start`.
- `score`  out  16  4 BCD digits, [15:12] = thousands.
- `hi_score`  out  16  4 BCD digits; best final score since reset.
- `lives`  out  2  remaining lives.
- `wave`  out  4  current wave; starts at 1.
- `invulnerable`  out  1  high while in RESPAWN.

## Operation
- States:
  - IDLE: reset state.
  - PLAYING.
  - RESPAWN: invulnerable.
  - OVER.
- Reset values: state IDLE, `score`=0, `hi_score`=0, `lives`=0, `wave`=0, `finished`=0, `invulnerable`=0, respawn counter 0.
- `start`, from any state: `score`=0, `lives`=START_LIVES, `wave`=1, `finished`=0, counter 0, next state PLAYING. `start` overrides every other event in the same cycle.
- Events are accepted only in PLAYING or RESPAWN with `is_playing`=1. In IDLE and OVER, all event inputs are ignored.
- `alien_hit` points, by `alien_row`:
  - 0: +30
  - 1: +20
  - 2 and 3: +10
  - Added with BCD carry per digit; result saturates at 9999.
- `wave_cleared`: `wave`+1, saturating at 15.
- `invaders_landed`: `lives`=0, `finished`=1, next state OVER.
- `player_hit` in PLAYING:
  - If `lives`=1: `lives`=0, `finished`=1, next state OVER.
  - Otherwise: `lives`−1, counter=RESPAWN_FRAMES, next state RESPAWN.
- `player_hit` in RESPAWN is ignored.
- RESPAWN: each `frame_tick` decrements the counter. When the counter reaches 0, next state is PLAYING on that same edge.
- Same-cycle priority: `start` > `invaders_landed` > `player_hit` > `frame_tick`. `alien_hit` and `wave_cleared` are still applied in a cycle that moves to OVER.
- `is_playing` falling in PLAYING or RESPAWN freezes all counters and the state. Activity resumes when it returns high.

## Timing
- All outputs are registered.
- `score`, `lives`, `wave` and `finished` update on the edge that samples the event, so they are visible 1 cycle after the pulse.
- `finished` is a level that stays high in OVER until `start`. The game-flow FSM may sample it on any later cycle.
- `hi_score` updates on the first edge spent in OVER, i.e. 1 cycle after `finished` rises, if `score` > `hi_score`. The comparison is an unsigned compare of the BCD words.
- `invulnerable` equals (state == RESPAWN), registered.
- `reset` asserted mid-game clears everything asynchronously. State is IDLE on release.

## Configuration
- `GAME_HISCORE_EN`:
  - Defined: high-score register and compare logic are present, as above.
  - Undefined: no register is built and `hi_score` is tied to 16'h0000.
  - All other behaviour is identical in both cases.

## Test plan
- Reset release, then `start` -> next cycle: `lives`=3, `wave`=1, `score`=16'h0000, `finished`=0, state PLAYING.
- With `is_playing`=1, `alien_hit` at rows 0, 1, 3 -> `score` steps 16'h0030, 16'h0050, 16'h0060. Preload to 16'h9990 plus a row-0 hit -> 16'h9999.
- `player_hit` with `lives`=3 -> `lives`=2 and `invulnerable`=1. Second `player_hit` during RESPAWN -> `lives` stays 2. After 90 `frame_tick` pulses -> `invulnerable`=0.
- `player_hit` with `lives`=1 -> `finished`=1 next cycle, then `hi_score`=`score` one cycle later. Further events are ignored. `start` -> `finished`=0, `score`=0, `hi_score` retained.
- Same cycle `invaders_landed`, `alien_hit` row 2 and `player_hit`, with `lives`=3 -> `lives`=0, `score`+10, `finished`=1.
- `reset` low mid-RESPAWN -> all outputs 0 immediately. With `GAME_HISCORE_EN` undefined -> `hi_score` is 0 after game over.
